deser_demux4: RTL
=================

DESER_DEMUX4 -- requirements
Module: deser_demux4

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of 4-bit output buffer entries (legal values 2 or 4).
REQ-002 SHALL have port CP, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port CDN, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port D, input, 1 bit: serial data bit.
REQ-005 SHALL have port SV, input, 1 bit: D is valid this cycle.
REQ-006 SHALL have port FS, input, 1 bit: frame start; qualified by SV, it marks D as bit 0 of a word.
REQ-007 SHALL have port Q, output, 4 bits: head word of the output buffer.
REQ-008 SHALL have port QV, output, 1 bit: Q is valid.
REQ-009 SHALL have port QR, input, 1 bit: the consumer accepts Q.
REQ-010 SHALL have port ERR, output, 1 bit: one-cycle error pulse.

Function
REQ-011 SHALL act as the 1:4 demux/deserializer end of the udp_mux4-based serializer: the first bit of a word maps to Q[0] (the in0 position) and the fourth bit maps to Q[3].
REQ-012 SHALL implement states IDLE, SHIFT and, only when built with PARITY_CHK_EN, PAR.
REQ-013 SHALL sample D only on cycles with SV=1; cycles with SV=0 hold all state.
REQ-014 In IDLE, SV=1 with FS=1 SHALL load the bit into position 0, set the 2-bit count to 1 and go to SHIFT; SV=1 with FS=0 SHALL be ignored.
REQ-015 In SHIFT, SV=1 with FS=0 SHALL load the bit at position count and increment count; the bit at count=3 completes the word, which then goes to PAR (when parity checking is built in) or is pushed and the block returns to IDLE.
REQ-016 In SHIFT or PAR, SV=1 with FS=1 SHALL abort the partial word, pulse ERR for 1 cycle, and restart at bit 0 (count=1, SHIFT).
REQ-017 A pushed word SHALL appear on Q with QV=1 one cycle after its completing bit is sampled (registered, latency 1).
REQ-018 Pop SHALL occur on a cycle with QV=1 and QR=1; Q and QV SHALL remain stable while QV=1 and QR=0.
REQ-019 The buffer SHALL be a FIFO with DEPTH entries and wrapping read/write pointers.
REQ-020 A push into a full buffer on the same cycle as a pop SHALL be accepted; a push into a full buffer without a pop SHALL drop the word and pulse ERR.
REQ-021 When the buffer is empty, QV SHALL be 0 and Q SHALL hold its last value.
REQ-022 A word completing on the same cycle as an FS abort cannot occur by construction, because FS=1 always denotes bit 0.

Reset
REQ-023 CDN=0 SHALL asynchronously force Q=4'b0000, QV=0, ERR=0, state=IDLE, count=0, and both buffer pointers and occupancy to 0.
REQ-024 Deassertion of CDN SHALL take effect at the next CP edge; a partial word in flight when CDN is asserted SHALL be discarded and never pushed.

Configuration
REQ-025 Macro PARITY_CHK_EN, when defined, SHALL add state PAR.
REQ-026 In PAR, the next SV=1 (FS=0) bit SHALL be the even-parity bit over the 4 data bits: on a match the word is pushed; on a mismatch the word is dropped and ERR pulses; either way the block returns to IDLE.
REQ-027 Without PARITY_CHK_EN, no parity bit SHALL be expected, and the word SHALL be pushed directly after bit 3.

Verification
REQ-028 Reset then FS+SV with D=1,0,1,1 over 4 SV cycles, QR=1 -> Q=4'b1101 and QV=1 one cycle after bit 3, popped on the same cycle; ERR stays 0.
REQ-029 SV gaps: bits 0,1,1,0 sent with SV toggling 1,0,1,0,... -> Q=4'b0110, with no extra or missing bits.
REQ-030 QR=0 with 3 words sent at DEPTH=2 -> first two words held in order, third word dropped, ERR pulses once; then QR=1 -> both held words pop and QV falls to 0.
REQ-031 FS reasserted after 2 bits -> ERR pulses 1 cycle, and the following 4 bits form the only word output.
REQ-032 CDN pulsed low mid-word and mid-buffer-full -> all outputs 0 immediately, and no stale word appears after release.
REQ-033 With PARITY_CHK_EN: data 1,1,0,0 followed by parity 0 -> Q=4'b0011 pushed; the same data followed by parity 1 -> no push, ERR pulses.

Source files
------------

// File: rtl/deser_demux4.sv
// deser_demux4: 1:4 serial-to-parallel deserializer with a DEPTH-entry output FIFO.
// Define PARITY_CHK_EN to expect an even-parity bit after each 4-bit word.
module deser_demux4 #(
    parameter int DEPTH = 2
) (
    input  logic       CP,
    input  logic       CDN,
    input  logic       D,
    input  logic       SV,
    input  logic       FS,
    input  logic       QR,
    output logic [3:0] Q,
    output logic       QV,
    output logic       ERR
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
`ifdef PARITY_CHK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
    state_t          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [3:0]      sh_q, sh_d;
    logic [3:0]      q_q, q_d;
    logic [3:0]      mem_q [DEPTH];
    logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic            err_q, err_d;
    logic            push_req, abort, fsm_err, pop, full, push, drop;

    assign Q   = q_q;
    assign QV  = occ_q != '0;
    assign ERR = err_q;

    // Word assembly: FS restarts at bit 0, other valid bits fill position cnt_q.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        push_req = 1'b0;
        abort    = 1'b0;
        fsm_err  = 1'b0;
        if (SV) begin
            if (FS) begin
                abort   = state_q != IDLE;
                sh_d    = {3'b000, D};
                cnt_d   = 2'd1;
                state_d = SHIFT;
            end else begin
                case (state_q)
                    SHIFT: begin
                        sh_d[cnt_q] = D;
                        cnt_d       = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
`ifdef PARITY_CHK_EN
                            state_d = PAR;
`else
                            push_req = 1'b1;
                            state_d  = IDLE;
`endif
                        end
                    end
`ifdef PARITY_CHK_EN
                    PAR: begin
                        push_req = D == ^sh_q;
                        fsm_err  = D != ^sh_q;
                        state_d  = IDLE;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // FIFO bookkeeping; a push into a full buffer is only accepted alongside a pop.
    always_comb begin
        pop   = QV & QR;
        full  = occ_q == OW'(DEPTH);
        push  = push_req & (~full | pop);
        drop  = push_req & full & ~pop;
        wp_d  = wp_q + AW'(push);
        rp_d  = rp_q + AW'(pop);
        occ_d = occ_q + OW'(push) - OW'(pop);
        q_d   = (occ_d == '0) ? q_q : ((occ_q == OW'(pop)) ? sh_d : mem_q[rp_d]);
        err_d = abort | fsm_err | drop;
    end

    // Control, pointers and the registered head word; reset discards any partial word.
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            sh_q    <= 4'd0;
            q_q     <= 4'd0;
            wp_q    <= '0;
            rp_q    <= '0;
            occ_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            q_q     <= q_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            occ_q   <= occ_d;
            err_q   <= err_d;
        end
    end

    // Buffer storage needs no reset: entries are only read while occupied.
    always_ff @(posedge CP) begin
        if (push) mem_q[wp_q] <= sh_d;
    end
endmodule
